gauss3_stream_filter: RTL and testbench
=======================================

# gauss3_stream_filter

Synthesizable streaming 3x3 binomial Gaussian filter and the hardware receiver of the greyscale pixel stream that the behavioural file-based filter model produces offline. It accepts one raster-order 8-bit pixel per handshake, buffers two lines, and emits one filtered pixel per input pixel. Borders are zero-padded against a fixed /16 normalisation, so for a given ROWS/COLS its output matches the model's Ksize=3 result with floor rounding.

## Interface
- ROWS, 168, image height in pixels (>= 2)
- COLS, 220, image width in pixels (>= 2)
- DW, 8, pixel width; kernel arithmetic below assumes 8
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  DW  input pixel, raster order, row 0 col 0 first
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  DW  filtered pixel
- m_sof  out  1  qualifies m_data as output pixel (0,0)
- m_eol  out  1  qualifies m_data as last pixel of a row
- busy  out  1  high in RUN or DRAIN

## Operation
- Kernel: outer product of [1 2 1] with itself, weights sum 16. sum = Σ w·p over in-bounds taps; out-of-image taps contribute 0; m_data = sum[11:4] (floor). sum is 12 bits unsigned, max 4080, no overflow.
- Storage: two COLS-deep line buffers (rows r-1, r) plus a 3x3 window shift register; input and line-buffer outputs shift in together on every advance.
- advance = (!m_valid || m_ready), plus in FILL/RUN a pixel accepted, in DRAIN unconditional.
- Output pixel (r,c) is computed on the advance that brings in input (r+1, c+1) (raster successor of (r,c) by COLS+1 positions).
- Masking: c==0 zeroes left column taps; c==COLS-1 zeroes right column taps (they hold wrapped next-row data); r==0 zeroes top row; r==ROWS-1 zeroes bottom row.
- FSM:
  - FILL (reset state): s_ready=1; accepts first COLS+1 pixels, no output; after the (COLS+1)th accept -> RUN.
  - RUN: s_ready = !m_valid || m_ready; each accept produces one output; after accepting pixel ROWS·COLS-1 (last) -> DRAIN.
  - DRAIN: s_ready=0; shifts in zero pixels, producing the remaining COLS+1 outputs; after output (ROWS-1, COLS-1) is loaded -> FILL, counters cleared.
- Per frame exactly ROWS·COLS outputs; m_sof on the first, m_eol on every COLS-th.
- Output counters (out_row, out_col) wrap col at COLS-1, row at ROWS-1.

## Timing
- Reset (async assert): m_valid=0, m_data=0, m_sof=0, m_eol=0, busy=0, state FILL, all counters 0; line buffer contents are don't-care (masked). s_ready=1 once state is FILL.
- m_data/m_sof/m_eol registered; m_valid rises the cycle after the advance that computes them.
- Latency: input (r+1,c+1) accepted at edge N -> output (r,c) valid from edge N (visible cycle N+1).
- m_valid held with stable data until m_ready; no output dropped or duplicated under any m_ready pattern.
- Throughput 1 pixel/cycle with m_ready tied high; DRAIN takes COLS+1 cycles at full rate.
- Back-to-back frames: next frame's first pixel accepted the cycle after DRAIN exits; no input accepted during DRAIN.
- rst_n asserted mid-frame: partial frame discarded, no further outputs; next frame starts clean in FILL.

## Structure
- Package gauss_pkg: kernel weight constants (1,2,1), SUM_W=12, NORM_SHIFT=4, state enum {FILL, RUN, DRAIN}.
- Sub-module gauss_line_buffer: COLS-deep, DW-wide delay line with enable, instantiated twice (cascaded), inferred RAM or registers.
- Top holds FSM, input/output counters, window, masking, adder tree, output register.

## Test plan
- ROWS=4, COLS=4, all pixels 255, m_ready=1 -> 16 outputs: corners 143, non-corner edges 191, interior 255; m_sof on #0, m_eol on #3,7,11,15.
- ROWS=5, COLS=5, single 160 at (2,2), rest 0 -> (2,2)=40; (1,2),(3,2),(2,1),(2,3)=20; diagonals=10; all else 0.
- Same impulse image, m_ready random 50% and s_valid random gaps -> output sequence bit-identical to previous test, exactly 25 outputs.
- Two consecutive 4x4 frames (ramp 0..15 then all 255), no gap -> second frame outputs 143/191/255 pattern, no contamination from frame 1.
- rst_n pulsed low after 9 pixels of a 4x4 frame -> m_valid 0 immediately, busy 0; fresh all-255 frame then yields correct 16 outputs.
- ROWS=168, COLS=220 random image vs model golden file -> all 36960 outputs match.

Source files
------------

// File: rtl/gauss_pkg.sv
// Shared constants and types for the 3x3 binomial stream filter.
package gauss_pkg;

  localparam logic [2:0] KW_0 = 3'd1;
  localparam logic [2:0] KW_1 = 3'd2;
  localparam logic [2:0] KW_2 = 3'd1;

  localparam int SUM_W      = 12;
  localparam int NORM_SHIFT = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [2:0] kw(input int idx);
    case (idx)
      0:       return KW_0;
      1:       return KW_1;
      default: return KW_2;
    endcase
  endfunction

endpackage

// File: rtl/gauss3_stream_filter_if.sv
// Pixel-in / filtered-pixel-out handshake bundle for gauss3_stream_filter.
interface gauss3_stream_filter_if #(
  parameter int DW = 8
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;

  // master: pixel source / output sink; slave: the filter
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eol
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eol
  );
endinterface

// File: rtl/gauss_line_buffer.sv
// DEPTH-entry delay line: q is the value written DEPTH enabled cycles earlier.
module gauss_line_buffer #(
  parameter int DEPTH = 220,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;

  // read-before-write at the same slot gives exactly DEPTH cycles of delay
  assign q = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
    end
  end
endmodule

// File: rtl/gauss3_stream_filter.sv
// Streaming 3x3 [1 2 1]x[1 2 1] /16 filter, zero-padded borders, two line buffers.
//
// state | meaning
// FILL  | priming line buffers with the first COLS+1 pixels, no output
// RUN   | one accepted pixel -> one output pixel
// DRAIN | input closed, zeros shifted in to flush the last COLS+1 outputs
module gauss3_stream_filter
  import gauss_pkg::*;
#(
  parameter int ROWS = 168,
  parameter int COLS = 220,
  parameter int DW   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gauss3_stream_filter_if.slave bus,
  output logic                  busy
);
  localparam int RW = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);
  localparam int CW = $clog2(ROWS * COLS);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CLW-1:0] COL_LAST  = CLW'(COLS - 1);
  localparam logic [CW-1:0]  IN_LAST   = CW'(ROWS * COLS - 1);
  localparam logic [CW-1:0]  FILL_LAST = CW'(COLS);

  state_t state, state_nx;

  logic [CW-1:0]  in_cnt;
  logic [RW-1:0]  out_row;
  logic [CLW-1:0] out_col;

  logic          out_free;
  logic          s_ready_c;
  logic          accept;
  logic          adv;
  logic          produce;
  logic [DW-1:0] pix_in;
  logic [DW-1:0] lb0_q;
  logic [DW-1:0] lb1_q;

  logic [DW-1:0] win  [3][3];
  logic [DW-1:0] nwin [3][3];
  logic [2:0]    row_ok;
  logic [2:0]    col_ok;
  logic [SUM_W-1:0] sum_c;

  logic          m_valid_q;
  logic [DW-1:0] m_data_q;
  logic          m_sof_q;
  logic          m_eol_q;

  assign out_free = !m_valid_q || bus.m_ready;
  assign accept   = bus.s_valid && s_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  // FILL shifts never touch the output register, so they ignore m_ready
  always_comb begin
    state_nx  = state;
    s_ready_c = 1'b0;
    adv       = 1'b0;
    produce   = 1'b0;
    pix_in    = bus.s_data;
    unique case (state)
      FILL: begin
        s_ready_c = 1'b1;
        adv       = bus.s_valid;
        if (adv && in_cnt == FILL_LAST) state_nx = RUN;
      end
      RUN: begin
        s_ready_c = out_free;
        adv       = bus.s_valid && out_free;
        produce   = adv;
        if (adv && in_cnt == IN_LAST) state_nx = DRAIN;
      end
      DRAIN: begin
        pix_in  = '0;
        adv     = out_free;
        produce = adv;
        if (adv && out_row == ROW_LAST && out_col == COL_LAST) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt  <= '0;
      out_row <= '0;
      out_col <= '0;
    end else begin
      if (accept) in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + CW'(1);
      if (produce) begin
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == ROW_LAST) ? '0 : out_row + RW'(1);
        end else begin
          out_col <= out_col + CLW'(1);
        end
      end
    end
  end

  gauss_line_buffer #(.DEPTH(COLS), .DW(DW)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .en(adv), .d(pix_in), .q(lb0_q)
  );

  gauss_line_buffer #(.DEPTH(COLS), .DW(DW)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .en(adv), .d(lb0_q), .q(lb1_q)
  );

  // row 0 = oldest line; the window after this advance is centred on (out_row, out_col)
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nwin[i][0] = win[i][1];
      nwin[i][1] = win[i][2];
    end
    nwin[0][2] = lb1_q;
    nwin[1][2] = lb0_q;
    nwin[2][2] = pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else if (adv) begin
      win <= nwin;
    end
  end

  always_comb begin
    row_ok = 3'b111;
    col_ok = 3'b111;
    if (out_row == '0)      row_ok[0] = 1'b0;
    if (out_row == ROW_LAST) row_ok[2] = 1'b0;
    if (out_col == '0)      col_ok[0] = 1'b0;
    if (out_col == COL_LAST) col_ok[2] = 1'b0;
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (row_ok[i] && col_ok[j])
          sum_c = sum_c + SUM_W'(nwin[i][j]) * SUM_W'(kw(i) * kw(j));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
    end else if (produce) begin
      m_valid_q <= 1'b1;
      m_data_q  <= DW'(sum_c >> NORM_SHIFT);
      m_sof_q   <= (out_row == '0) && (out_col == '0);
      m_eol_q   <= (out_col == COL_LAST);
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_sof   = m_sof_q;
  assign bus.m_eol   = m_eol_q;
  assign busy        = (state != FILL);
endmodule

// File: tb/tb_gauss3_stream_filter.sv
// Scoreboard bench for gauss3_stream_filter: 4x4, 5x5 and 168x220 instances share one stimulus driver.
module tb_gauss3_stream_filter;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eol;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gauss3_stream_filter_if #(.DW(8)) if_a ();
  gauss3_stream_filter_if #(.DW(8)) if_b ();
  gauss3_stream_filter_if #(.DW(8)) if_c ();
  logic busy_a, busy_b, busy_c;

  gauss3_stream_filter #(.ROWS(4), .COLS(4), .DW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .busy(busy_a));
  gauss3_stream_filter #(.ROWS(5), .COLS(5), .DW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .busy(busy_b));
  gauss3_stream_filter #(.ROWS(168), .COLS(220), .DW(8)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c), .busy(busy_c));

  int         sel;
  logic       drv_valid;
  logic [7:0] drv_data;
  logic       m_ready_d;
  bit         rnd_ready;

  assign if_a.s_valid = drv_valid && (sel == 0);
  assign if_b.s_valid = drv_valid && (sel == 1);
  assign if_c.s_valid = drv_valid && (sel == 2);
  assign if_a.s_data  = drv_data;
  assign if_b.s_data  = drv_data;
  assign if_c.s_data  = drv_data;
  assign if_a.m_ready = m_ready_d;
  assign if_b.m_ready = m_ready_d;
  assign if_c.m_ready = m_ready_d;

  logic       obs_s_ready, obs_m_valid, obs_sof, obs_eol, obs_busy;
  logic [7:0] obs_m_data;

  always_comb begin
    obs_s_ready = if_a.s_ready;
    obs_m_valid = if_a.m_valid;
    obs_m_data  = if_a.m_data;
    obs_sof     = if_a.m_sof;
    obs_eol     = if_a.m_eol;
    obs_busy    = busy_a;
    if (sel == 1) begin
      obs_s_ready = if_b.s_ready;
      obs_m_valid = if_b.m_valid;
      obs_m_data  = if_b.m_data;
      obs_sof     = if_b.m_sof;
      obs_eol     = if_b.m_eol;
      obs_busy    = busy_b;
    end else if (sel == 2) begin
      obs_s_ready = if_c.s_ready;
      obs_m_valid = if_c.m_valid;
      obs_m_data  = if_c.m_data;
      obs_sof     = if_c.m_sof;
      obs_eol     = if_c.m_eol;
      obs_busy    = busy_c;
    end
  end

  exp_t sb[$];
  int   img[];
  int   n_checks;
  int   n_pass;
  int   out_count;
  int   busy_cycles;

  task automatic monitor();
    exp_t got, e, held;
    bit   hold_pending;
    hold_pending = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = {obs_m_data, obs_sof, obs_eol};
      if (rst_n) begin
        if (obs_busy) busy_cycles++;
        if (hold_pending && obs_m_valid) begin
          n_checks++;
          if (got !== held)
            $display("FAIL hold_stable got=%0d/%0b/%0b want=%0d/%0b/%0b",
                     got.d, got.sof, got.eol, held.d, held.sof, held.eol);
          else n_pass++;
        end
        if (obs_m_valid && m_ready_d) begin
          n_checks++;
          if (sb.size() == 0) begin
            $display("FAIL unexpected_output got=%0d/%0b/%0b want=none", got.d, got.sof, got.eol);
          end else begin
            e = sb.pop_front();
            if (got !== e)
              $display("FAIL output_word #%0d got=%0d/sof%0b/eol%0b want=%0d/sof%0b/eol%0b",
                       out_count, got.d, got.sof, got.eol, e.d, e.sof, e.eol);
            else n_pass++;
          end
          out_count++;
        end
        hold_pending = obs_m_valid && !m_ready_d;
        held = got;
      end else begin
        hold_pending = 1'b0;
      end
    end
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge clk);
      #1;
      m_ready_d = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  endtask

  // Pushes the whole frame's expected outputs, then drives npix pixels of img.
  task automatic drive_frame(input int rows, input int cols, input bit gaps,
                             input int npix, output int first_wait);
    int   wt[3];
    int   s, rr, cc, waited;
    bit   acc;
    exp_t e;
    wt[0] = 1; wt[1] = 2; wt[2] = 1;
    first_wait = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        s = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++) begin
            rr = r + dr - 1;
            cc = c + dc - 1;
            if (rr >= 0 && rr < rows && cc >= 0 && cc < cols)
              s += wt[dr] * wt[dc] * img[rr * cols + cc];
          end
        e.d   = 8'(s / 16);
        e.sof = (r == 0) && (c == 0);
        e.eol = (c == cols - 1);
        sb.push_back(e);
      end
    end
    for (int k = 0; k < npix; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        drv_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      drv_valid = 1'b1;
      drv_data  = 8'(img[k]);
      waited = 0;
      acc = 1'b0;
      while (!acc && waited < 1000) begin
        @(negedge clk);
        acc = obs_s_ready;
        @(posedge clk);
        #1;
        waited++;
      end
      if (k == 0) first_wait = waited;
      if (!acc) begin
        n_checks++;
        $display("FAIL input_accept pixel=%0d s_ready low for %0d cycles, want accepted", k, waited);
        drv_valid = 1'b0;
        return;
      end
    end
    drv_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || obs_busy) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({obs_m_valid, obs_m_data, obs_sof, obs_eol} !== 11'b0)
      $display("FAIL reset_outputs got v=%0b d=%0d sof=%0b eol=%0b want all 0",
               obs_m_valid, obs_m_data, obs_sof, obs_eol);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({obs_s_ready, obs_busy} !== 2'b10)
      $display("FAIL reset_fill got s_ready=%0b busy=%0b want s_ready=1 busy=0", obs_s_ready, obs_busy);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_all255();
    int n0, fw;
    sel = 0;
    img = new[16];
    foreach (img[i]) img[i] = 255;
    busy_cycles = 0;
    n0 = out_count;
    drive_frame(4, 4, 1'b0, 16, fw);
    wait_idle();
    n_checks++;
    if (out_count - n0 !== 16) $display("FAIL all255_count got=%0d want=16", out_count - n0);
    else n_pass++;
    // 11 RUN accepts + COLS+1 drain cycles at full rate
    n_checks++;
    if (busy_cycles !== 16) $display("FAIL all255_busy_cycles got=%0d want=16", busy_cycles);
    else n_pass++;
  endtask

  task automatic test_impulse();
    int n0, fw;
    sel = 1;
    img = new[25];
    foreach (img[i]) img[i] = 0;
    img[12] = 160;
    n0 = out_count;
    drive_frame(5, 5, 1'b0, 25, fw);
    wait_idle();
    n_checks++;
    if (out_count - n0 !== 25) $display("FAIL impulse_count got=%0d want=25", out_count - n0);
    else n_pass++;
  endtask

  task automatic test_impulse_stall();
    int n0, fw;
    sel = 1;
    rnd_ready = 1'b1;
    n0 = out_count;
    drive_frame(5, 5, 1'b1, 25, fw);
    wait_idle();
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_count - n0 !== 25) $display("FAIL stall_count got=%0d want=25", out_count - n0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n0, fw;
    sel = 0;
    img = new[16];
    foreach (img[i]) img[i] = i;
    n0 = out_count;
    drive_frame(4, 4, 1'b0, 16, fw);
    foreach (img[i]) img[i] = 255;
    drive_frame(4, 4, 1'b0, 16, fw);
    // DRAIN holds s_ready low for COLS+1 cycles, first accept one cycle later
    n_checks++;
    if (fw !== 6) $display("FAIL b2b_first_accept_wait got=%0d want=6", fw);
    else n_pass++;
    wait_idle();
    n_checks++;
    if (out_count - n0 !== 32) $display("FAIL b2b_count got=%0d want=32", out_count - n0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n0, fw;
    sel = 0;
    img = new[16];
    foreach (img[i]) img[i] = 3 * i + 7;
    n0 = out_count;
    drive_frame(4, 4, 1'b0, 9, fw);
    n_checks++;
    if (obs_m_valid !== 1'b1) $display("FAIL midrst_pre_valid got=%0b want=1", obs_m_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({obs_m_valid, obs_busy} !== 2'b00)
      $display("FAIL midrst_outputs got m_valid=%0b busy=%0b want 0/0", obs_m_valid, obs_busy);
    else n_pass++;
    n_checks++;
    if (out_count - n0 !== 3) $display("FAIL midrst_consumed got=%0d want=3", out_count - n0);
    else n_pass++;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (img[i]) img[i] = 255;
    n0 = out_count;
    drive_frame(4, 4, 1'b0, 16, fw);
    wait_idle();
    n_checks++;
    if (out_count - n0 !== 16) $display("FAIL midrst_fresh_count got=%0d want=16", out_count - n0);
    else n_pass++;
  endtask

  task automatic test_large();
    int n0, fw;
    sel = 2;
    img = new[168 * 220];
    foreach (img[i]) img[i] = int'($urandom_range(0, 255));
    n0 = out_count;
    drive_frame(168, 220, 1'b0, 168 * 220, fw);
    wait_idle();
    n_checks++;
    if (out_count - n0 !== 36960) $display("FAIL large_count got=%0d want=36960", out_count - n0);
    else n_pass++;
  endtask

  initial begin
    sel         = 0;
    drv_valid   = 1'b0;
    drv_data    = '0;
    m_ready_d   = 1'b1;
    rnd_ready   = 1'b0;
    rst_n       = 1'b0;
    n_checks    = 0;
    n_pass      = 0;
    out_count   = 0;
    busy_cycles = 0;
    fork
      monitor();
      ready_gen();
    join_none
    test_reset();
    test_all255();
    test_impulse();
    test_impulse_stall();
    test_back_to_back();
    test_reset_mid();
    test_large();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
